sequential_normalizer: RTL
==========================

Name: sequential_normalizer

Overview:
- Multi-cycle inverse of the arithmetic shifter: takes a signed word and left-shifts it until it is normalized.
- Normalized means the two MSBs differ.
- Reports the normalized word and the shift amount applied, so a downstream arithmetic right shift by that amount restores the original value.
- Sits after wide accumulators and arithmetic shifters, ahead of block-floating-point and requantization logic.
- Valid/ready on both sides; one word in flight at a time.

Parameters:
- data_width, 24, width of dataIn/dataOut (signed, two's complement).
- shiftBits, log2(data_width) (localparam), width of amount; 5 at default.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inValid  input  1  dataIn valid.
- inReady  output  1  block can accept a word.
- dataIn  input  data_width  signed word to normalize.
- outValid  output  1  result valid.
- outReady  input  1  consumer accepts result.
- dataOut  output  data_width  normalized word: dataIn <<< amount.
- amount  output  shiftBits  number of left shifts applied, 0..data_width-1.
- zero  output  1  dataIn was all zeros.

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, inReady=1, outValid=0, dataOut=0, amount=0, zero=0.
- Reset mid-operation aborts any word in flight; nothing is output for it.
- Registers: shift register R (data_width), counter C (shiftBits).
- State IDLE:
  - inReady=1, outValid=0.
  - On inValid&inReady at a clock edge: R<=dataIn, C<=0, go to SHIFT.
- State SHIFT:
  - inReady=0.
  - Each edge: if R[W-1]!=R[W-2] or C==W-1, go to DONE.
  - Otherwise R<=R<<1 (zero fill) and C<=C+1.
- Entering DONE registers: dataOut<=R, amount<=C, zero<=(R==0), outValid<=1.
- State DONE:
  - inReady=0; outputs held stable while outValid=1 and outReady=0.
  - On outValid&outReady at an edge: outValid<=0, go to IDLE.
  - dataOut, amount and zero retain their values until the next result.
- Latency: outValid rises amount+1 edges after the acceptance edge.
  - Worst case is data_width edges (zero, or -1 input).
- Throughput: one word per amount+3 cycles minimum. No back-to-back overlap; inValid is ignored outside IDLE.
- Boundary cases:
  - Already-normalized input: amount=0, latency 1.
  - Zero input: amount=W-1, dataOut=0, zero=1.
  - All-ones (-1): amount=W-1, dataOut=100..0, zero=0.
  - Most negative value (10..0): amount=0.
- Sign is preserved for every nonzero input. Overflow is impossible because shifting stops when the MSBs differ.
- outReady high while outValid is low has no effect.
- inValid held high through DONE is not consumed until the cycle after return to IDLE.

Optional Feature:
- Macro: NORM_FAST_STEP_EN.
- Defined: in SHIFT, if R[W-1]==R[W-2]==R[W-3] and C<=W-3, then R<=R<<2 and C<=C+2 in one edge. Otherwise the single-step rule applies.
- dataOut, amount and zero are identical to the undefined case; only latency shrinks, to ceil(amount/2)+1 edges.
- Undefined: strictly one bit per edge as specified above.

Test Plan:
- Reset: assert rst_n=0 with arbitrary inputs -> inReady=1, outValid=0, dataOut=0, amount=0, zero=0. Deassert; block is idle.
- Small positive: dataIn=0x000001 -> dataOut=0x400000, amount=22, zero=0. outValid 23 edges after acceptance (12 with NORM_FAST_STEP_EN).
- Negative and normalized edges:
  - 0xC00000 -> dataOut=0x800000, amount=1.
  - 0x400000 -> dataOut=0x400000, amount=0, latency 1.
  - 0xFFFFFF -> dataOut=0x800000, amount=23, zero=0.
- Zero: dataIn=0x000000 -> dataOut=0, amount=23, zero=1, latency 24.
- Backpressure: hold outReady=0 for 5 cycles after outValid -> outputs stable, inReady=0. A new inValid pulse is ignored. After outReady=1 for one edge, outValid=0 and inReady=1.
- Reset mid-shift: drive rst_n low during SHIFT for 0x000001 -> outputs immediately at reset values. No outValid after release; the next word 0x000100 gives amount=14.

Source files
------------

// File: rtl/sequential_normalizer.sv
// Multi-cycle normalizer: left-shifts a signed word until its two MSBs differ and
// reports the shift amount. Optional macro NORM_FAST_STEP_EN allows two-bit steps.
module sequential_normalizer #(
  parameter int data_width = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [data_width-1:0]         dataIn,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [data_width-1:0]         dataOut,
  output logic [$clog2(data_width)-1:0] amount,
  output logic                          zero
);

  localparam int shiftBits = $clog2(data_width);
  localparam logic [shiftBits-1:0] C_MAX = shiftBits'(data_width - 1);
  localparam logic [shiftBits-1:0] C_ONE = shiftBits'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [data_width-1:0]  r_r;
  logic [shiftBits-1:0]   c_r;
  logic                   stop_s;

  assign stop_s = (r_r[data_width-1] != r_r[data_width-2]) || (c_r == C_MAX);

`ifdef NORM_FAST_STEP_EN
  localparam logic [shiftBits-1:0] C_FAST = shiftBits'(data_width - 3);
  localparam logic [shiftBits-1:0] C_TWO  = shiftBits'(2);
  logic fast_s;
  // Three equal top bits guarantee the single-step rule would shift twice in a row.
  assign fast_s = (r_r[data_width-1] == r_r[data_width-2]) &&
                  (r_r[data_width-2] == r_r[data_width-3]) && (c_r <= C_FAST);
`endif

  // Control FSM with shift datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      r_r      <= '0;
      c_r      <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      dataOut  <= '0;
      amount   <= '0;
      zero     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (inValid && inReady) begin
            r_r     <= dataIn;
            c_r     <= '0;
            inReady <= 1'b0;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (stop_s) begin
            dataOut  <= r_r;
            amount   <= c_r;
            zero     <= (r_r == '0);
            outValid <= 1'b1;
            state_r  <= DONE;
`ifdef NORM_FAST_STEP_EN
          end else if (fast_s) begin
            r_r <= {r_r[data_width-3:0], 2'b00};
            c_r <= c_r + C_TWO;
`endif
          end else begin
            r_r <= {r_r[data_width-2:0], 1'b0};
            c_r <= c_r + C_ONE;
          end
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state_r  <= IDLE;
          end
        end
        default: begin
          outValid <= 1'b0;
          inReady  <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
